// File: rtl/bullet_attack_engine_pkg.sv
// Shared definitions for the bullet attack engine slice.
// Contents: game-state decode, coordinate widths, FSM encoding and a small
// zero-extension helper used for overflow-free coordinate arithmetic.
package bullet_attack_engine_pkg;

   localparam int unsigned COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COORD_W:0]   wide_t;

   localparam logic [1:0] STATE_BATTLE = 2'd1;

   localparam logic [1:0] FSM_IDLE = 2'd0;
   localparam logic [1:0] FSM_RUN  = 2'd1;
   localparam logic [1:0] FSM_HALT = 2'd2;

   function automatic wide_t ext(input coord_t v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/bullet_attack_engine_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left.
// Ports: clk, reset (sync, active-high, loads SEED), advance (step once),
// lfsr_out (current register value).
module bullet_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   output logic [15:0] lfsr_out
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign lfsr_out = lfsr_q;

endmodule

// File: rtl/bullet_attack_engine.sv
// Enemy bullet generator for the battle box.
// Moves NUM_BULLETS square bullets (even slots rightwards, odd slots
// leftwards) once per frame_tick, respawns one slot per tick, draws them per
// pixel and reports heart overlap as a single-cycle collision pulse.
// Ports: clk/reset (sync, active-high), frame_tick, state, hp, pixel x/y,
// playerSpriteOn, four 9-bit box borders; outputs bulletSpriteOn
// (registered), collision, activeMask, invulnerable.
module bullet_attack_engine
   import bullet_attack_engine_pkg::*;
#(
   parameter int unsigned NUM_BULLETS   = 4,
   parameter int unsigned BULLET_SIZE   = 8,
   parameter int unsigned STEP          = 2,
   parameter int unsigned INVULN_FRAMES = 30,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [1:0]             state,
   input  logic [1:0]             hp,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   input  logic                   playerSpriteOn,
   input  logic [8:0]             leftBorder,
   input  logic [8:0]             rightBorder,
   input  logic [8:0]             topBorder,
   input  logic [8:0]             bottomBorder,
   output logic                   bulletSpriteOn,
   output logic                   collision,
   output logic [NUM_BULLETS-1:0] activeMask,
   output logic                   invulnerable
);

   localparam int unsigned        INV_W    = $clog2(INVULN_FRAMES + 1);
   localparam logic [INV_W-1:0]   INV_LOAD = INV_W'(INVULN_FRAMES);
   localparam logic [INV_W-1:0]   INV_ONE  = INV_W'(1);
   localparam wide_t              SZ       = wide_t'(BULLET_SIZE);
   localparam wide_t              STEP_W   = wide_t'(STEP);
   localparam wide_t              W_ONE    = wide_t'(1);

   logic [1:0]             fsm_q, fsm_d;
   logic [NUM_BULLETS-1:0] active_q, active_d;
   coord_t                 bx_q [NUM_BULLETS];
   coord_t                 bx_d [NUM_BULLETS];
   coord_t                 by_q [NUM_BULLETS];
   coord_t                 by_d [NUM_BULLETS];
   logic [INV_W-1:0]       invuln_q, invuln_d;
   logic                   hit_q, hit_d;
   logic                   sprite_q, sprite_d;

   logic [15:0] lfsr_val;
   logic        lfsr_adv;
   logic        lfsr_unused;
   logic        run_upd;
   logic        spawn_done;
   logic        pix_on;
   wide_t       l_e, r_e, t_e, b_e, x_e, y_e;
   wide_t       ycand;
   coord_t      spawn_y;

   bullet_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .advance  (lfsr_adv),
      .lfsr_out (lfsr_val)
   );

   assign lfsr_unused = ^lfsr_val[15:7];

   assign l_e = {2'b00, leftBorder};
   assign r_e = {2'b00, rightBorder};
   assign t_e = {2'b00, topBorder};
   assign b_e = {2'b00, bottomBorder};
   assign x_e = ext(x);
   assign y_e = ext(y);

   assign ycand   = t_e + wide_t'(lfsr_val[6:0]);
   assign spawn_y = (ycand + SZ > b_e) ? coord_t'(t_e + W_ONE) : coord_t'(ycand);

   // Frame work only while battle is still requested; a state drop or reset
   // in the same cycle suppresses movement, spawning and the hit pulse.
   assign run_upd = (fsm_q == FSM_RUN) && (state == STATE_BATTLE) && !reset;

   always_comb begin
      pix_on = 1'b0;
      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
         if (active_q[i] &&
             x_e >= ext(bx_q[i]) && x_e < ext(bx_q[i]) + SZ &&
             y_e >= ext(by_q[i]) && y_e < ext(by_q[i]) + SZ) begin
            pix_on = 1'b1;
         end
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      active_d   = active_q;
      bx_d       = bx_q;
      by_d       = by_q;
      invuln_d   = invuln_q;
      hit_d      = hit_q;
      lfsr_adv   = 1'b0;
      spawn_done = 1'b0;
      collision  = 1'b0;
      sprite_d   = 1'b0;

      case (fsm_q)
         FSM_IDLE: if (state == STATE_BATTLE) fsm_d = FSM_RUN;
         FSM_RUN: begin
            if (state != STATE_BATTLE) fsm_d = FSM_IDLE;
            else if (hp == 2'd0)       fsm_d = FSM_HALT;
         end
         FSM_HALT: if (state != STATE_BATTLE) fsm_d = FSM_IDLE;
         default:  fsm_d = FSM_IDLE;
      endcase

      if (run_upd && frame_tick) begin
         for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (active_q[i]) begin
               if ((i % 2) == 0) begin
                  if (ext(bx_q[i]) + STEP_W + SZ > r_e) active_d[i] = 1'b0;
                  else                                  bx_d[i] = bx_q[i] + coord_t'(STEP);
               end else begin
                  // x-STEP <= left rewritten to avoid unsigned underflow
                  if (ext(bx_q[i]) <= l_e + STEP_W) active_d[i] = 1'b0;
                  else                              bx_d[i] = bx_q[i] - coord_t'(STEP);
               end
            end
         end
         // Eligibility uses the pre-tick mask, so a slot retired above is not reused now.
         for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            if (!active_q[i] && !spawn_done) begin
               spawn_done  = 1'b1;
               active_d[i] = 1'b1;
               bx_d[i]     = ((i % 2) == 0) ? coord_t'(l_e + W_ONE) : coord_t'(r_e - SZ);
               by_d[i]     = spawn_y;
            end
         end
         lfsr_adv = spawn_done;
         if (hit_q) begin
            collision = 1'b1;
            invuln_d  = INV_LOAD;
            hit_d     = 1'b0;
         end else if (invuln_q != '0) begin
            invuln_d = invuln_q - INV_ONE;
         end
      end

      // An overlap on the reporting tick itself must not re-arm the latch.
      if (run_upd && sprite_q && playerSpriteOn && invuln_q == '0 && !(frame_tick && hit_q)) begin
         hit_d = 1'b1;
      end

      if (fsm_d == FSM_IDLE) begin
         active_d = '0;
         hit_d    = 1'b0;
         invuln_d = '0;
      end else begin
         sprite_d = pix_on;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q    <= FSM_IDLE;
         active_q <= '0;
         for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            bx_q[i] <= '0;
            by_q[i] <= '0;
         end
         invuln_q <= '0;
         hit_q    <= 1'b0;
         sprite_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         active_q <= active_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         invuln_q <= invuln_d;
         hit_q    <= hit_d;
         sprite_q <= sprite_d;
      end
   end

   assign bulletSpriteOn = sprite_q;
   assign activeMask     = active_q;
   assign invulnerable   = (invuln_q != '0);

endmodule

// File: doc/bullet_attack_engine.md
Name: bullet_attack_engine

Overview:
Enemy-attack generator for the battle box. It moves NUM_BULLETS square bullets across the box bounded by leftBorder/rightBorder/topBorder/bottomBorder, and draws them per pixel. It detects overlap with the heart sprite and emits the single-cycle `collision` pulse consumed by player_sprite for hp decrement. It sits beside player_sprite and is muxed into the VGA pixel path.

Parameters:
NUM_BULLETS, 4, number of bullet slots (2..8)
BULLET_SIZE, 8, bullet width = height in pixels
STEP, 2, pixels moved per frame_tick
INVULN_FRAMES, 30, frame_ticks of hit immunity after a collision pulse
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
state  in  2  game state; 1 = battle
hp  in  2  current player hp
x, y  in  10  current pixel coordinate
playerSpriteOn  in  1  registered heart-pixel flag, aligned with bulletSpriteOn
leftBorder, rightBorder, topBorder, bottomBorder  in  9  battle box; zero-extended to 10 bits
bulletSpriteOn  out  1  registered: pixel (x,y) of previous cycle lies in an active bullet
collision  out  1  one-cycle hit pulse
activeMask  out  NUM_BULLETS  per-slot active flag
invulnerable  out  1  high while invuln counter nonzero

Behaviour:
- Reset: FSM=IDLE, all slots inactive, bullet x/y=0, lfsr=LFSR_SEED, invuln_cnt=0, hit_latched=0. All outputs are 0.
- FSM:
  - IDLE -> RUN when state==1.
  - RUN -> HALT when hp==0.
  - RUN or HALT -> IDLE when state!=1. Entering IDLE clears slots, hit_latched and invuln_cnt. The lfsr is not reseeded.
  - HALT: bullets freeze and are still drawn, collision is never asserted, and the invuln counter stops.
- Updates in RUN happen only on frame_tick. All active slots update in parallel.
  - Even slot i moves right: if x+STEP+BULLET_SIZE > rightBorder, the slot goes inactive; else x += STEP.
  - Odd slot i moves left: if x-STEP <= leftBorder, the slot goes inactive; else x -= STEP.
  - Respawn: on the same tick, the lowest-indexed slot that was inactive before the tick is spawned. At most one spawn per tick.
    - Spawn x: leftBorder+1 (even slot) or rightBorder-BULLET_SIZE (odd slot).
    - Spawn y: ycand = topBorder + lfsr[6:0]. If ycand+BULLET_SIZE > bottomBorder, y = topBorder+1; else y = ycand.
  - The lfsr advances only on a spawn. It is a Fibonacci LFSR with taps 16,14,13,11, shifting left: new bit = l[15]^l[13]^l[12]^l[10] enters bit 0.
  - A slot deactivated on a tick is not respawned on that same tick.
- Pixel path, every cycle in RUN or HALT:
  - bulletSpriteOn <= OR over active slots of (x>=bx && x<bx+BULLET_SIZE && y>=by && y<by+BULLET_SIZE).
  - In IDLE, bulletSpriteOn <= 0.
  - Comparisons use 11-bit sums so there is no wrap-around.
- Hit detection:
  - In RUN, if playerSpriteOn && bulletSpriteOn && invuln_cnt==0, then hit_latched <= 1.
  - On frame_tick in RUN:
    - If hit_latched: collision=1 for that single cycle, invuln_cnt <= INVULN_FRAMES, hit_latched <= 0.
    - Else, if invuln_cnt>0, decrement it.
  - Multiple overlaps within one frame yield exactly one pulse.
  - An overlap in the same cycle as frame_tick is latched and reported at the next tick.
- invulnerable = (invuln_cnt != 0), combinational from the register.
- reset has priority over frame_tick and state.

Decomposition:
- Shared package: game-state constants (STATE_BATTLE=1), coordinate width (10), FSM state encoding (IDLE, RUN, HALT).
- One natural sub-module: bullet_lfsr (16-bit, seed parameter, advance enable, 16-bit out).

Test Plan:
- Borders L=200,R=440,T=200,B=360, state=1, reset released, first frame_tick -> slot0 active at x=201, y=200+0x61=297; activeMask=4'b0001.
- Second frame_tick -> slot0 x=203; slot1 spawns at x=432 with y from the next LFSR value; activeMask=4'b0011. Run ticks until slot0 has x+2+8>440 -> that slot is inactive on that tick and respawns on the next tick.
- Pixel (205,300) one cycle after bullet at (203,297) -> bulletSpriteOn=1; pixel (211,300) -> 0.
- Hold playerSpriteOn=1 during overlap for 3 cycles in one frame -> exactly one collision pulse at the next frame_tick; invulnerable=1 for 30 ticks; overlaps during those 30 ticks produce no pulse; a pulse is possible again after tick 30.
- hp=0 while in RUN -> HALT; positions frozen across ticks; collision stays 0 despite overlap.
- state drops to 0 mid-invulnerability -> next cycle activeMask=0, invulnerable=0, bulletSpriteOn=0; reset asserted together with frame_tick -> all outputs 0.
